// File: rtl/bus_datapath_pkg.sv
// Shared control-signal definitions for the bus datapath and its control unit:
// control-word bit positions, control-word width, default data/address widths
// and the bus-source priority decode.
package bus_datapath_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned CONTROL_WIDTH  = 16;

    // One bit per micro-operation in the control word
    localparam int unsigned c_HALT         = 0;
    localparam int unsigned c_MAR_IN       = 1;
    localparam int unsigned c_RAM_IN       = 2;
    localparam int unsigned c_RAM_OUT      = 3;
    localparam int unsigned c_IR_IN        = 4;
    localparam int unsigned c_IR_OUT       = 5;
    localparam int unsigned c_A_IN         = 6;
    localparam int unsigned c_A_OUT        = 7;
    localparam int unsigned c_B_IN         = 8;
    localparam int unsigned c_OUT_IN       = 9;
    localparam int unsigned c_ALU_OUT      = 10;
    localparam int unsigned c_ALU_SUB      = 11;
    localparam int unsigned c_PC_INC       = 12;
    localparam int unsigned c_PC_OUT       = 13;
    localparam int unsigned c_JUMP         = 14;
    localparam int unsigned c_FLAGS_UPDATE = 15;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_PC,
        SRC_IR,
        SRC_RAM,
        SRC_A,
        SRC_ALU
    } bus_src_e;

    // Fixed-priority bus source: ALU > A > RAM > IR > PC, nothing otherwise
    function automatic bus_src_e bus_select(input logic [CONTROL_WIDTH-1:0] ctrl);
        if (ctrl[c_ALU_OUT]) return SRC_ALU;
        if (ctrl[c_A_OUT])   return SRC_A;
        if (ctrl[c_RAM_OUT]) return SRC_RAM;
        if (ctrl[c_IR_OUT])  return SRC_IR;
        if (ctrl[c_PC_OUT])  return SRC_PC;
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/bus_datapath_alu.sv
// Adder/subtractor for the bus datapath. Subtraction is A + ~B + 1, so the
// carry out reads 1 when no borrow occurred.
module alu #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  alu_sub,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry
);
    import bus_datapath_pkg::*;

    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH:0]   sum;

    // Widened add with optional inversion and carry-in for subtract
    always_comb begin
        operand = alu_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, operand} + (DATA_WIDTH + 1)'(alu_sub);
        result  = sum[DATA_WIDTH-1:0];
        carry   = sum[DATA_WIDTH];
    end

endmodule

// File: rtl/bus_datapath.sv
// Single-bus datapath: A/B/IR/MAR/PC/OUT registers, RAM with asynchronous
// read, ALU and flags, halt latch and a program-load port.
// Optional feature: define BUS_CONTENTION_CHK_EN to add the sticky
// o_BUS_ERROR output flagging multiple simultaneous bus drivers.
module bus_datapath #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned CONTROL_WIDTH = bus_datapath_pkg::CONTROL_WIDTH
) (
    input  logic                       i_CLOCK,
    input  logic                       i_RESET_n,
    input  logic [CONTROL_WIDTH-1:0]   i_CONTROL_SIGNALS,
    input  logic                       i_LOAD_EN,
    input  logic [ADDR_WIDTH-1:0]      i_LOAD_ADDR,
    input  logic [DATA_WIDTH-1:0]      i_LOAD_DATA,
    output logic [DATA_WIDTH/2-1:0]    o_IR_DATA,
    output logic                       o_ZERO_FLAG,
    output logic                       o_CARRY_FLAG,
    output logic [DATA_WIDTH-1:0]      o_OUT_DATA,
    output logic                       o_HALTED
`ifdef BUS_CONTENTION_CHK_EN
    ,
    output logic                       o_BUS_ERROR
`endif
);
    import bus_datapath_pkg::*;

    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] ir_reg;
    logic [DATA_WIDTH-1:0] out_reg;
    logic [ADDR_WIDTH-1:0] mar;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  zero_flag;
    logic                  carry_flag;
    logic                  halted;

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    logic [DATA_WIDTH-1:0] bus;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_carry;
    logic                  ctrl_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a       (a_reg),
        .b       (b_reg),
        .alu_sub (i_CONTROL_SIGNALS[c_ALU_SUB]),
        .result  (alu_result),
        .carry   (alu_carry)
    );

    // Bus multiplexer with fixed source priority
    always_comb begin
        bus = '0;
        case (bus_select(i_CONTROL_SIGNALS))
            SRC_ALU: bus = alu_result;
            SRC_A:   bus = a_reg;
            SRC_RAM: bus = ram[mar];
            SRC_IR:  bus = DATA_WIDTH'(ir_reg[DATA_WIDTH/2-1:0]);
            SRC_PC:  bus = DATA_WIDTH'(pc);
            default: bus = '0;
        endcase
    end

    // Control word acts only when not loading a program and not halted;
    // RAM write port is resolved here so reset can veto it on the same edge
    always_comb begin
        ctrl_en   = !i_LOAD_EN && !halted;
        ram_we    = 1'b0;
        ram_waddr = mar;
        ram_wdata = bus;
        if (i_RESET_n) begin
            if (i_LOAD_EN) begin
                ram_we    = 1'b1;
                ram_waddr = i_LOAD_ADDR;
                ram_wdata = i_LOAD_DATA;
            end else if (ctrl_en && i_CONTROL_SIGNALS[c_RAM_IN]) begin
                ram_we = 1'b1;
            end
        end
    end

    // RAM storage: not cleared by reset
    always_ff @(posedge i_CLOCK) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Register file, PC, flags and halt latch
    always_ff @(posedge i_CLOCK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            ir_reg     <= '0;
            out_reg    <= '0;
            mar        <= '0;
            pc         <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            halted     <= 1'b0;
        end else if (ctrl_en) begin
            if (i_CONTROL_SIGNALS[c_MAR_IN]) mar     <= bus[ADDR_WIDTH-1:0];
            if (i_CONTROL_SIGNALS[c_IR_IN])  ir_reg  <= bus;
            if (i_CONTROL_SIGNALS[c_A_IN])   a_reg   <= bus;
            if (i_CONTROL_SIGNALS[c_B_IN])   b_reg   <= bus;
            if (i_CONTROL_SIGNALS[c_OUT_IN]) out_reg <= bus;
            if (i_CONTROL_SIGNALS[c_JUMP]) begin
                pc <= bus[ADDR_WIDTH-1:0];
            end else if (i_CONTROL_SIGNALS[c_PC_INC]) begin
                pc <= pc + ADDR_WIDTH'(1);
            end
            if (i_CONTROL_SIGNALS[c_FLAGS_UPDATE]) begin
                zero_flag  <= (alu_result == '0);
                carry_flag <= alu_carry;
            end
            if (i_CONTROL_SIGNALS[c_HALT]) halted <= 1'b1;
        end
    end

`ifdef BUS_CONTENTION_CHK_EN
    // Sticky contention flag: more than one bus driver requested on an edge
    always_ff @(posedge i_CLOCK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            o_BUS_ERROR <= 1'b0;
        end else if ($countones({i_CONTROL_SIGNALS[c_ALU_OUT], i_CONTROL_SIGNALS[c_A_OUT],
                                 i_CONTROL_SIGNALS[c_RAM_OUT], i_CONTROL_SIGNALS[c_IR_OUT],
                                 i_CONTROL_SIGNALS[c_PC_OUT]}) > 1) begin
            o_BUS_ERROR <= 1'b1;
        end
    end
`endif

    assign o_IR_DATA    = ir_reg[DATA_WIDTH-1:DATA_WIDTH/2];
    assign o_ZERO_FLAG  = zero_flag;
    assign o_CARRY_FLAG = carry_flag;
    assign o_OUT_DATA   = out_reg;
    assign o_HALTED     = halted;

endmodule

// File: tb/tb_bus_datapath.sv
// Self-checking bench for bus_datapath: directed micro-op sequences followed
// by randomized control words, all checked against an arithmetic model.
module tb_bus_datapath;
    import bus_datapath_pkg::*;

    localparam int unsigned CW = CONTROL_WIDTH;
    localparam logic [CW-1:0] K_HALT  = CW'(1) << c_HALT;
    localparam logic [CW-1:0] K_MARI  = CW'(1) << c_MAR_IN;
    localparam logic [CW-1:0] K_RAMI  = CW'(1) << c_RAM_IN;
    localparam logic [CW-1:0] K_RAMO  = CW'(1) << c_RAM_OUT;
    localparam logic [CW-1:0] K_IRI   = CW'(1) << c_IR_IN;
    localparam logic [CW-1:0] K_IRO   = CW'(1) << c_IR_OUT;
    localparam logic [CW-1:0] K_AI    = CW'(1) << c_A_IN;
    localparam logic [CW-1:0] K_AO    = CW'(1) << c_A_OUT;
    localparam logic [CW-1:0] K_BI    = CW'(1) << c_B_IN;
    localparam logic [CW-1:0] K_OUTI  = CW'(1) << c_OUT_IN;
    localparam logic [CW-1:0] K_ALUO  = CW'(1) << c_ALU_OUT;
    localparam logic [CW-1:0] K_SUB   = CW'(1) << c_ALU_SUB;
    localparam logic [CW-1:0] K_INC   = CW'(1) << c_PC_INC;
    localparam logic [CW-1:0] K_PCO   = CW'(1) << c_PC_OUT;
    localparam logic [CW-1:0] K_JUMP  = CW'(1) << c_JUMP;
    localparam logic [CW-1:0] K_FLAGS = CW'(1) << c_FLAGS_UPDATE;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] ctrl;
    logic          load_en;
    logic [3:0]    load_addr;
    logic [7:0]    load_data;
    logic [3:0]    ir_data;
    logic          zero_flag;
    logic          carry_flag;
    logic [7:0]    out_data;
    logic          halted;
`ifdef BUS_CONTENTION_CHK_EN
    logic          bus_error;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    int m_a, m_b, m_ir, m_mar, m_pc, m_out, m_z, m_c, m_halt, m_err;
    int m_ram [16];

    bus_datapath #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CONTROL_WIDTH(CW)) dut (
        .i_CLOCK           (clk),
        .i_RESET_n         (rst_n),
        .i_CONTROL_SIGNALS (ctrl),
        .i_LOAD_EN         (load_en),
        .i_LOAD_ADDR       (load_addr),
        .i_LOAD_DATA       (load_data),
        .o_IR_DATA         (ir_data),
        .o_ZERO_FLAG       (zero_flag),
        .o_CARRY_FLAG      (carry_flag),
        .o_OUT_DATA        (out_data),
        .o_HALTED          (halted)
`ifdef BUS_CONTENTION_CHK_EN
        ,
        .o_BUS_ERROR       (bus_error)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_ir = 0; m_mar = 0; m_pc = 0;
        m_out = 0; m_z = 0; m_c = 0; m_halt = 0; m_err = 0;
    endtask

    // Behaviour of one clock edge computed from the datapath rules
    task automatic model_step(input logic [CW-1:0] c, input bit le, input int la, input int ld);
        int sum, bus, drivers;
        sum = c[c_ALU_SUB] ? m_a + 256 - m_b : m_a + m_b;
        if (c[c_ALU_OUT])      bus = sum % 256;
        else if (c[c_A_OUT])   bus = m_a;
        else if (c[c_RAM_OUT]) bus = m_ram[m_mar];
        else if (c[c_IR_OUT])  bus = m_ir % 16;
        else if (c[c_PC_OUT])  bus = m_pc;
        else                   bus = 0;
        drivers = int'(c[c_ALU_OUT]) + int'(c[c_A_OUT]) + int'(c[c_RAM_OUT])
                + int'(c[c_IR_OUT]) + int'(c[c_PC_OUT]);
        if (drivers > 1) m_err = 1;
        if (le) begin
            m_ram[la] = ld;
        end else if (m_halt == 0) begin
            if (c[c_RAM_IN]) m_ram[m_mar] = bus;
            if (c[c_MAR_IN]) m_mar = bus % 16;
            if (c[c_IR_IN])  m_ir  = bus;
            if (c[c_A_IN])   m_a   = bus;
            if (c[c_B_IN])   m_b   = bus;
            if (c[c_OUT_IN]) m_out = bus;
            if (c[c_JUMP])        m_pc = bus % 16;
            else if (c[c_PC_INC]) m_pc = (m_pc + 1) % 16;
            if (c[c_FLAGS_UPDATE]) begin
                m_z = (sum % 256 == 0) ? 1 : 0;
                m_c = (sum >= 256) ? 1 : 0;
            end
            if (c[c_HALT]) m_halt = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out"},    32'(out_data),   m_out);
        chk({tag, ".zero"},   32'(zero_flag),  m_z);
        chk({tag, ".carry"},  32'(carry_flag), m_c);
        chk({tag, ".ir_hi"},  32'(ir_data),    m_ir / 16);
        chk({tag, ".halted"}, 32'(halted),     m_halt);
`ifdef BUS_CONTENTION_CHK_EN
        chk({tag, ".bus_err"}, 32'(bus_error), m_err);
`endif
    endtask

    task automatic apply(input logic [CW-1:0] c, input bit le, input int la, input int ld);
        ctrl      = c;
        load_en   = le;
        load_addr = 4'(la);
        load_data = 8'(ld);
        @(posedge clk);
        #1;
        model_step(c, le, la, ld);
        check_outputs("step");
    endtask

    task automatic probe(input string tag, input logic [CW-1:0] src, input int exp);
        apply(src | K_OUTI, 1'b0, 0, 0);
        chk(tag, 32'(out_data), exp);
    endtask

    task automatic set_pc(input int k);
        apply(K_JUMP, 1'b0, 0, 0);
        repeat (k) apply(K_INC, 1'b0, 0, 0);
    endtask

    task automatic set_mar(input int k);
        set_pc(k);
        apply(K_PCO | K_MARI, 1'b0, 0, 0);
    endtask

    // Place a value in a register through scratch RAM word 12
    task automatic set_reg(input int val, input logic [CW-1:0] dest);
        apply('0, 1'b1, 12, val);
        set_mar(12);
        apply(K_RAMO | dest, 1'b0, 0, 0);
    endtask

    // Asynchronous reset, held across one edge carrying a busy control word and a load
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs("reset_async");
        ctrl      = K_AO | K_OUTI | K_INC | K_HALT | K_FLAGS | K_AI;
        load_en   = 1'b1;
        load_addr = 4'd12;
        load_data = 8'hEE;
        @(posedge clk);
        #1;
        check_outputs("reset_edge");
        @(negedge clk);
        rst_n   = 1'b1;
        ctrl    = '0;
        load_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        ctrl = '0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < 16; i++) m_ram[i] = 0;
        #1;
        do_reset();

        // Fill RAM with known contents
        for (int i = 0; i < 16; i++) apply('0, 1'b1, i, int'($urandom_range(0, 255)));

        // LDA 14 ; ADD 15
        apply('0, 1'b1, 0, 8'h1E);
        apply('0, 1'b1, 1, 8'h2F);
        apply('0, 1'b1, 14, 8'h05);
        apply('0, 1'b1, 15, 8'h03);
        apply(K_PCO | K_MARI, 1'b0, 0, 0);
        apply(K_RAMO | K_IRI | K_INC, 1'b0, 0, 0);
        chk("lda_opcode", 32'(ir_data), 1);
        apply(K_IRO | K_MARI, 1'b0, 0, 0);
        apply(K_RAMO | K_AI, 1'b0, 0, 0);
        apply(K_PCO | K_MARI, 1'b0, 0, 0);
        apply(K_RAMO | K_IRI | K_INC, 1'b0, 0, 0);
        chk("add_opcode", 32'(ir_data), 2);
        apply(K_IRO | K_MARI, 1'b0, 0, 0);
        apply(K_RAMO | K_BI, 1'b0, 0, 0);
        apply(K_ALUO | K_AI | K_FLAGS, 1'b0, 0, 0);
        chk("add_zero", 32'(zero_flag), 0);
        chk("add_carry", 32'(carry_flag), 0);
        probe("add_result", K_AO, 8'h08);

        // Subtract: equal operands, then borrow
        set_reg(3, K_AI);
        set_reg(3, K_BI);
        apply(K_ALUO | K_SUB | K_AI | K_FLAGS, 1'b0, 0, 0);
        chk("sub_eq_zero", 32'(zero_flag), 1);
        chk("sub_eq_carry", 32'(carry_flag), 1);
        probe("sub_eq_result", K_AO, 8'h00);
        set_reg(2, K_AI);
        set_reg(3, K_BI);
        apply(K_ALUO | K_SUB | K_AI | K_FLAGS, 1'b0, 0, 0);
        chk("sub_borrow_zero", 32'(zero_flag), 0);
        chk("sub_borrow_carry", 32'(carry_flag), 0);
        probe("sub_borrow_result", K_AO, 8'hFF);

        // PC wrap and jump precedence
        set_pc(15);
        probe("pc_15", K_PCO, 8'h0F);
        apply(K_INC, 1'b0, 0, 0);
        probe("pc_wrap", K_PCO, 8'h00);
        set_reg(8'h8A, K_IRI);
        chk("ir_8a_hi", 32'(ir_data), 8);
        apply(K_INC | K_JUMP | K_IRO, 1'b0, 0, 0);
        probe("jump_over_inc", K_PCO, 8'h0A);

        // Load strobe overrides the control word
        set_reg(8'h21, K_AI);
        probe("out_a21", K_AO, 8'h21);
        apply(K_AO | K_OUTI, 1'b1, 5, 8'h99);
        chk("load_blocks_out", 32'(out_data), 8'h21);
        set_mar(5);
        probe("load_wrote_ram", K_RAMO, 8'h99);

        // Halt suppresses control writes; reset clears it and keeps RAM
        set_reg(8'h11, K_AI);
        set_reg(8'h47, K_IRI);
        probe("pre_halt_pc", K_PCO, 8'h0C);
        apply(K_HALT, 1'b0, 0, 0);
        chk("halted_set", 32'(halted), 1);
        apply(K_AI | K_IRO, 1'b0, 0, 0);
        apply(K_AO | K_OUTI | K_FLAGS | K_JUMP, 1'b0, 0, 0);
        chk("halt_out_hold", 32'(out_data), 8'h0C);
        chk("halt_still", 32'(halted), 1);
        apply('0, 1'b1, 3, 8'h5A);
        do_reset();
        chk("reset_halted", 32'(halted), 0);
        chk("reset_out", 32'(out_data), 0);
        probe("reset_a", K_AO, 8'h00);
        probe("reset_pc", K_PCO, 8'h00);
        set_mar(12);
        probe("ram_kept_12", K_RAMO, 8'h47);
        set_mar(3);
        probe("ram_load_halted", K_RAMO, 8'h5A);

`ifdef BUS_CONTENTION_CHK_EN
        apply(K_AO | K_RAMO, 1'b0, 0, 0);
        chk("contention_set", 32'(bus_error), 1);
        apply('0, 1'b0, 0, 0);
        apply(K_AO | K_OUTI, 1'b0, 0, 0);
        chk("contention_sticky", 32'(bus_error), 1);
        do_reset();
        chk("contention_cleared", 32'(bus_error), 0);
`endif

        // Randomized control words and occasional loads
        for (int i = 0; i < 400; i++) begin
            logic [CW-1:0] c;
            bit le;
            c  = CW'($urandom) & ~K_HALT;
            le = ($urandom_range(0, 7) == 0);
            apply(c, le, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            if (i % 5 == 4) apply(K_AO | K_OUTI, 1'b0, 0, 0);
            if (i % 7 == 6) apply(K_ALUO | K_OUTI, 1'b0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_datapath.md
BUS_DATAPATH -- requirements
Module: bus_datapath

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bus, register and RAM word width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the PC/MAR width; RAM depth is 2^ADDR_WIDTH.
REQ-003 Parameter CONTROL_WIDTH, default from the shared package, SHALL set the control-word width.
REQ-004 Port i_CLOCK, in, 1: the single clock; all state updates on its rising edge.
REQ-005 Port i_RESET_n, in, 1: reset, asynchronous, active-low.
REQ-006 Port i_CONTROL_SIGNALS, in, CONTROL_WIDTH: control word from the control unit, one c_* bit per micro-operation.
REQ-007 Port i_LOAD_EN, in, 1: program-load strobe.
REQ-008 Port i_LOAD_ADDR, in, ADDR_WIDTH: program-load RAM address.
REQ-009 Port i_LOAD_DATA, in, DATA_WIDTH: program-load RAM data.
REQ-010 Port o_IR_DATA, out, DATA_WIDTH/2: IR upper half (opcode) to the control unit.
REQ-011 Port o_ZERO_FLAG, out, 1: registered zero flag.
REQ-012 Port o_CARRY_FLAG, out, 1: registered carry flag.
REQ-013 Port o_OUT_DATA, out, DATA_WIDTH: output-register contents.
REQ-014 Port o_HALTED, out, 1: halt latch state.

Function
REQ-015 Bus source SHALL be selected by fixed priority ALU_OUT > A_OUT > RAM_OUT > IR_OUT > PC_OUT; bus = 0 when no *_OUT bit is set.
REQ-016 IR_OUT SHALL drive IR lower half zero-extended; PC_OUT SHALL drive PC zero-extended; RAM_OUT SHALL drive RAM[MAR] (asynchronous read).
REQ-017 On a clock edge, each asserted *_IN bit (MAR, IR, A, B, OUT, RAM) SHALL load its target from the bus; MAR takes bus[ADDR_WIDTH-1:0]; several targets may load in one cycle.
REQ-018 PC_INC SHALL increment PC modulo 2^ADDR_WIDTH (15 -> 0); JUMP SHALL load PC from bus[ADDR_WIDTH-1:0] and take precedence over PC_INC.
REQ-019 ALU SHALL compute a DATA_WIDTH+1-bit result: A+B, or A+~B+1 when ALU_SUB; carry = bit DATA_WIDTH (subtract: 1 = no borrow).
REQ-020 ALU inputs SHALL be current register values; ALU_OUT|A_IN in one cycle writes A with the result from the old A.
REQ-021 FLAGS_UPDATE SHALL latch zero = (ALU result[DATA_WIDTH-1:0] == 0) and carry; flags otherwise hold.
REQ-022 HALT SHALL set the halt latch; while halted, all register, PC, flag and RAM writes from i_CONTROL_SIGNALS SHALL be suppressed.
REQ-023 i_LOAD_EN SHALL write i_LOAD_DATA to RAM[i_LOAD_ADDR] on the edge and suppress all control-word effects that cycle, halted or not.

Reset
REQ-024 Reset assertion SHALL immediately clear A, B, IR, MAR, PC, OUT, both flags and the halt latch to 0; RAM contents SHALL be retained.
REQ-025 Reset mid-instruction SHALL take precedence over any control word or load on the same edge.

Configuration
REQ-026 With BUS_CONTENTION_CHK_EN defined, an extra output o_BUS_ERROR (1 bit) SHALL be a sticky flag set when more than one *_OUT bit is asserted on a clock edge, cleared only by reset.
REQ-027 Without BUS_CONTENTION_CHK_EN, the port and logic SHALL be absent; priority selection (REQ-015) applies in both builds.

Structure
REQ-028 c_* control-bit positions, CONTROL_WIDTH and width constants SHALL live in the shared control-signals package used by the control unit.
REQ-029 ALU SHALL be a separate sub-module named alu (inputs A, B, ALU_SUB; outputs result, carry).

Verification
REQ-030 Load RAM[14]=0x05, RAM[15]=0x03; execute LDA 14, ADD 15 -> A=0x08, ZERO=0, CARRY=0.
REQ-031 A=0x03, B=0x03, SUB with FLAGS_UPDATE -> A=0x00, ZERO=1, CARRY=1; A=0x02, B=0x03 SUB -> A=0xFF, ZERO=0, CARRY=0.
REQ-032 PC=15 with PC_INC -> PC=0; PC_INC|JUMP|IR_OUT with IR=0x8A -> PC=0xA.
REQ-033 HALT asserted, then A_IN|IR_OUT with IR=0x47 -> A unchanged, o_HALTED=1; i_RESET_n low -> o_HALTED=0, all registers 0, RAM preserved.
REQ-034 A=0x21 with A_OUT|OUT_IN -> o_OUT_DATA=0x21; i_LOAD_EN with same word -> o_OUT_DATA unchanged, RAM written.
REQ-035 (BUS_CONTENTION_CHK_EN) A_OUT|RAM_OUT one cycle -> o_BUS_ERROR=1 and stays 1 until reset.
